// File: rtl/io_stream_router.sv
`default_nettype none
// ============================================================================
// Module   : io_stream_router
// Purpose  : Assembles a received UART byte stream into little-endian words.
//            Boot phase: a two-word header (N_I, N_D) is followed by N_I
//            instruction words and N_D data words, which are written to the
//            instruction and data memories. Run phase: completed words feed
//            an input FIFO that serves core input requests. Core output bytes
//            are queued in an output FIFO that drains to the transmitter.
// Ports    : clk, rstn (async, active low)
//            rx_data/rx_valid                 - received byte stream
//            tx_data/tx_valid/tx_ready        - transmitter handshake
//            instr_waddr/instr_wdata/instr_we - instruction write (pulse)
//            data_waddr/data_wdata/data_we/data_ack - data write (held)
//            io_stall                         - high until run phase
//            input_req/input_data/input_data_ready - core input words
//            output_data/output_valid/output_busy  - core output bytes
//            overflow                         - sticky drop flag
// Options  : IO_CHECKSUM_EN - adds a CSUM state that sends the XOR of all
//            loaded bytes to the transmitter before entering run phase.
// Revision : 1.0 - initial release
// ============================================================================
module io_stream_router #(
  parameter int                WORD_BYTES = 4,
  parameter int                ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] DATA_BASE  = 'h40000,
  parameter int                IN_DEPTH   = 16,
  parameter int                OUT_DEPTH  = 16
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic [7:0]                rx_data,
  input  logic                      rx_valid,
  output logic [7:0]                tx_data,
  output logic                      tx_valid,
  input  logic                      tx_ready,
  output logic [ADDR_W-1:0]         instr_waddr,
  output logic [8*WORD_BYTES-1:0]   instr_wdata,
  output logic                      instr_we,
  output logic [ADDR_W-1:0]         data_waddr,
  output logic [8*WORD_BYTES-1:0]   data_wdata,
  output logic                      data_we,
  input  logic                      data_ack,
  output logic                      io_stall,
  input  logic                      input_req,
  output logic [8*WORD_BYTES-1:0]   input_data,
  output logic                      input_data_ready,
  input  logic [7:0]                output_data,
  input  logic                      output_valid,
  output logic                      output_busy,
  output logic                      overflow
);

  localparam int              c_W    = 8 * WORD_BYTES;
  localparam int              c_BCW  = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
  localparam int              c_IAW  = $clog2(IN_DEPTH);
  localparam int              c_OAW  = $clog2(OUT_DEPTH);
  localparam logic [c_W-1:0]  c_ONE  = {{(c_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] c_STEP = ADDR_W'(WORD_BYTES);

  typedef enum logic [2:0] {
    HDR_I  = 3'd0,
    HDR_D  = 3'd1,
    LOAD_I = 3'd2,
    LOAD_D = 3'd3,
`ifdef IO_CHECKSUM_EN
    CSUM   = 3'd5,
`endif
    RUN    = 3'd4
  } state_t;

`ifdef IO_CHECKSUM_EN
  localparam state_t c_END = CSUM;
`else
  localparam state_t c_END = RUN;
`endif

  state_t r_state, w_next_state;

  // ---------------- byte assembly ----------------
  logic [c_BCW-1:0] r_byte_cnt;
  logic [c_W-1:0]   r_asm, w_word;
  logic             w_word_done;

  // w_word is the word including the byte arriving this cycle, so a
  // completed word is usable in the same cycle as its last byte.
  always_comb begin
    w_word = r_asm;
    for (int k = 0; k < WORD_BYTES; k++) begin
      if (r_byte_cnt == c_BCW'(k)) w_word[8*k +: 8] = rx_data;
    end
  end
  assign w_word_done = rx_valid && (r_byte_cnt == c_BCW'(WORD_BYTES - 1));

  // ---------------- boot counters / write ports ----------------
  logic [c_W-1:0]    r_n_i, r_n_d, r_icnt, r_dwords, r_dacks;
  logic [ADDR_W-1:0] r_instr_waddr, r_data_waddr;
  logic [c_W-1:0]    r_instr_wdata, r_data_wdata;
  logic              r_instr_we, r_data_we, r_overflow;
  logic [7:0]        r_csum;
  logic              w_ack;

  assign w_ack = r_data_we && data_ack;

  // ---------------- FSM next state ----------------
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      HDR_I:  if (w_word_done) w_next_state = HDR_D;
      HDR_D:  if (w_word_done) begin
                if (r_n_i != '0)       w_next_state = LOAD_I;
                else if (w_word != '0) w_next_state = LOAD_D;
                else                   w_next_state = c_END;
              end
      LOAD_I: if (w_word_done && (r_icnt + c_ONE == r_n_i))
                w_next_state = (r_n_d != '0) ? LOAD_D : c_END;
      // Leave only once the last data write has been accepted.
      LOAD_D: if (w_ack && (r_dacks + c_ONE == r_n_d)) w_next_state = c_END;
`ifdef IO_CHECKSUM_EN
      CSUM:   if (tx_ready) w_next_state = RUN;
`endif
      RUN:    w_next_state = RUN;
      default: w_next_state = HDR_I;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= HDR_I;
    else       r_state <= w_next_state;
  end

  // ---------------- input FIFO ----------------
  logic [c_W-1:0] r_in_mem [IN_DEPTH];
  logic [c_IAW:0] r_in_wr, r_in_rd, r_req_cnt;
  logic [c_W-1:0] r_input_data;
  logic           r_input_ready;
  logic w_in_empty, w_in_full, w_in_push, w_req_pend, w_in_pop, w_in_bypass;
  logic w_in_write, w_in_drop, w_deliver;

  assign w_in_empty  = (r_in_wr == r_in_rd);
  assign w_in_full   = (r_in_wr[c_IAW] != r_in_rd[c_IAW]) &&
                       (r_in_wr[c_IAW-1:0] == r_in_rd[c_IAW-1:0]);
  assign w_in_push   = (r_state == RUN) && w_word_done;
  // A request arriving this cycle counts, giving one-cycle latency.
  assign w_req_pend  = (r_req_cnt != '0) || input_req;
  assign w_in_pop    = w_req_pend && !w_in_empty;
  // Empty FIFO with a waiting request: hand the new word straight over.
  assign w_in_bypass = w_req_pend && w_in_empty && w_in_push;
  assign w_in_write  = w_in_push && !w_in_full && !w_in_bypass;
  assign w_in_drop   = w_in_push && w_in_full;
  assign w_deliver   = w_in_pop || w_in_bypass;

  always_ff @(posedge clk) begin
    if (w_in_write) r_in_mem[r_in_wr[c_IAW-1:0]] <= w_word;
  end

  // ---------------- output FIFO ----------------
  logic [7:0]     r_out_mem [OUT_DEPTH];
  logic [c_OAW:0] r_out_wr, r_out_rd;
  logic w_out_empty, w_out_full, w_out_push, w_out_drop, w_out_pop, w_in_csum;

  assign w_out_empty = (r_out_wr == r_out_rd);
  assign w_out_full  = (r_out_wr[c_OAW] != r_out_rd[c_OAW]) &&
                       (r_out_wr[c_OAW-1:0] == r_out_rd[c_OAW-1:0]);
  assign w_out_push  = output_valid && !w_out_full;
  assign w_out_drop  = output_valid && w_out_full;
`ifdef IO_CHECKSUM_EN
  assign w_in_csum   = (r_state == CSUM);
`else
  assign w_in_csum   = 1'b0;
`endif
  assign w_out_pop   = !w_in_csum && !w_out_empty && tx_ready;

  always_ff @(posedge clk) begin
    if (w_out_push) r_out_mem[r_out_wr[c_OAW-1:0]] <= output_data;
  end

  // ---------------- datapath registers ----------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_byte_cnt    <= '0;
      r_asm         <= '0;
      r_n_i         <= '0;
      r_n_d         <= '0;
      r_icnt        <= '0;
      r_dwords      <= '0;
      r_dacks       <= '0;
      r_instr_waddr <= '0;
      r_instr_wdata <= '0;
      r_instr_we    <= 1'b0;
      r_data_waddr  <= DATA_BASE;
      r_data_wdata  <= '0;
      r_data_we     <= 1'b0;
      r_overflow    <= 1'b0;
      r_csum        <= 8'h00;
      r_in_wr       <= '0;
      r_in_rd       <= '0;
      r_req_cnt     <= '0;
      r_input_data  <= '0;
      r_input_ready <= 1'b0;
      r_out_wr      <= '0;
      r_out_rd      <= '0;
    end else begin
      if (rx_valid) begin
        r_asm      <= w_word;
        r_byte_cnt <= w_word_done ? '0 : r_byte_cnt + 1'b1;
      end
      if (r_state == HDR_I && w_word_done) r_n_i <= w_word;
      if (r_state == HDR_D && w_word_done) r_n_d <= w_word;

      // Instruction write: pulse one cycle after the word completes.
      r_instr_we <= (r_state == LOAD_I) && w_word_done;
      if ((r_state == LOAD_I) && w_word_done) begin
        r_instr_wdata <= w_word;
        r_icnt        <= r_icnt + c_ONE;
      end
      if (r_instr_we) r_instr_waddr <= r_instr_waddr + c_STEP;

      // Data write: held until acknowledged; a new word overrides the clear.
      if (w_ack) begin
        r_data_we    <= 1'b0;
        r_data_waddr <= r_data_waddr + c_STEP;
        r_dacks      <= r_dacks + c_ONE;
      end
      if ((r_state == LOAD_D) && w_word_done && !(r_data_we && !data_ack) &&
          (r_dwords != r_n_d)) begin
        r_data_we    <= 1'b1;
        r_data_wdata <= w_word;
        r_dwords     <= r_dwords + c_ONE;
      end

      if (rx_valid && (r_state == LOAD_I || r_state == LOAD_D))
        r_csum <= r_csum ^ rx_data;

      if (w_in_drop || w_out_drop ||
          ((r_state == LOAD_D) && w_word_done && r_data_we && !data_ack))
        r_overflow <= 1'b1;

      if (w_in_write) r_in_wr <= r_in_wr + 1'b1;
      if (w_in_pop)   r_in_rd <= r_in_rd + 1'b1;
      case ({input_req, w_deliver})
        2'b10:   r_req_cnt <= r_req_cnt + 1'b1;
        2'b01:   r_req_cnt <= r_req_cnt - 1'b1;
        default: r_req_cnt <= r_req_cnt;
      endcase
      r_input_ready <= w_deliver;
      if (w_deliver) r_input_data <= w_in_pop ? r_in_mem[r_in_rd[c_IAW-1:0]] : w_word;

      if (w_out_push) r_out_wr <= r_out_wr + 1'b1;
      if (w_out_pop)  r_out_rd <= r_out_rd + 1'b1;
    end
  end

  // ---------------- outputs ----------------
  assign instr_waddr      = r_instr_waddr;
  assign instr_wdata      = r_instr_wdata;
  assign instr_we         = r_instr_we;
  assign data_waddr       = r_data_waddr;
  assign data_wdata       = r_data_wdata;
  assign data_we          = r_data_we;
  assign io_stall         = (r_state != RUN);
  assign input_data       = r_input_data;
  assign input_data_ready = r_input_ready;
  assign output_busy      = w_out_full;
  assign overflow         = r_overflow;
  assign tx_valid         = w_in_csum || !w_out_empty;
  assign tx_data          = w_in_csum   ? r_csum :
                            w_out_empty ? 8'h00  : r_out_mem[r_out_rd[c_OAW-1:0]];

endmodule
`default_nettype wire
